// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl
// Keypad operand-entry controller for the Booth multiplier datapath.
// Builds signed decimal operands A and B from debounced key codes. It
// supports sign toggle, backspace, clear, range checking and a digit-count
// limit. The completed pair is offered to the multiplier over a
// valid/ready handshake.
module operand_entry_ctrl #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3,
  parameter int DCNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_value,
  input  logic             key_pressed,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  output logic [WIDTH-1:0] disp_value,
  output logic             entry_sel,
  output logic             err
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Key codes above the decimal digits.
  localparam logic [3:0] KEY_STAR  = 4'hA;  // advance to operand B
  localparam logic [3:0] KEY_NEG   = 4'hB;  // toggle sign
  localparam logic [3:0] KEY_CLR   = 4'hC;  // clear / step back to A
  localparam logic [3:0] KEY_ENTER = 4'hD;  // commit operand pair
  localparam logic [3:0] KEY_BKSP  = 4'hE;  // drop last digit

  localparam int EXT_W = WIDTH + 4;

  // Largest legal magnitude, 2^(WIDTH-1)-1, at the extended width.
  localparam logic [EXT_W-1:0]  MAG_LIMIT = {5'b0, {(WIDTH-1){1'b1}}};
  localparam logic [EXT_W-1:0]  TEN_EXT   = EXT_W'(10);
  localparam logic [WIDTH-1:0]  TEN_W     = WIDTH'(10);
  localparam logic [DCNT_W-1:0] MAX_DCNT  = DCNT_W'(MAX_DIGITS);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  // Registered state
  state_t            state;
  logic [WIDTH-1:0]  mag;
  logic              neg;
  logic [DCNT_W-1:0] dcnt;
  logic              key_prev;

  // Next-state values
  state_t            state_nxt;
  logic [WIDTH-1:0]  mag_nxt;
  logic              neg_nxt;
  logic [DCNT_W-1:0] dcnt_nxt;
  logic [WIDTH-1:0]  op_a_nxt;
  logic [WIDTH-1:0]  op_b_nxt;
  logic              op_valid_nxt;
  logic              entry_sel_nxt;
  logic              err_nxt;

  // Decode helpers
  logic              key_ev;
  logic              is_digit;
  logic              lead_zero;
  logic [EXT_W-1:0]  mag_x10;
  logic [WIDTH-1:0]  mag_div10;
  logic              has_value;
  logic              entry_dirty;
  logic              digit_ok;

  // Rising edge of the debounced key level gives one action per press.
  assign key_ev = key_pressed & ~key_prev;

  assign is_digit  = (key_value <= 4'd9);
  assign lead_zero = (key_value == 4'd0) && (mag == '0);

  // Candidate magnitude after appending a digit, wide enough not to wrap.
  assign mag_x10   = ({4'b0, mag} * TEN_EXT) + {{WIDTH{1'b0}}, key_value};
  assign mag_div10 = mag / TEN_W;
  assign digit_ok  = (dcnt < MAX_DCNT) && (mag_x10 <= MAG_LIMIT);

  // '*' and '=' need a real value; a bare sign or leading zeros do not count.
  assign has_value   = (dcnt != '0) || (mag != '0);
  // Clear treats a pending sign as content worth wiping first.
  assign entry_dirty = (dcnt != '0) || neg;

  // Negative zero collapses to 0 because -0 == 0 in two's complement.
  assign disp_value = neg ? (-mag) : mag;

  // Next-state and datapath decisions for every key and handshake event.
  // NOTE: every *_nxt gets a default before the case so no latch is inferred
  // on paths that leave a value untouched.
  always_comb begin
    state_nxt     = state;
    mag_nxt       = mag;
    neg_nxt       = neg;
    dcnt_nxt      = dcnt;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    op_valid_nxt  = op_valid;
    entry_sel_nxt = entry_sel;
    err_nxt       = 1'b0;

    case (state)
      HOLD: begin
        // Keys are ignored here; only the handshake moves us on.
        if (op_valid && op_ready) begin
          op_valid_nxt  = 1'b0;
          mag_nxt       = '0;
          neg_nxt       = 1'b0;
          dcnt_nxt      = '0;
          entry_sel_nxt = 1'b0;
          state_nxt     = ENTRY_A;
        end
      end

      ENTRY_A, ENTRY_B: begin
        if (key_ev) begin
          if (is_digit) begin
            if (lead_zero) begin
              // Leading zero keeps mag at 0 and does not use a digit slot.
              mag_nxt = '0;
            end else if (digit_ok) begin
              mag_nxt  = mag_x10[WIDTH-1:0];
              dcnt_nxt = dcnt + DCNT_ONE;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            case (key_value)
              KEY_STAR: begin
                if ((state == ENTRY_A) && has_value) begin
                  op_a_nxt      = disp_value;
                  mag_nxt       = '0;
                  neg_nxt       = 1'b0;
                  dcnt_nxt      = '0;
                  entry_sel_nxt = 1'b1;
                  state_nxt     = ENTRY_B;
                end else begin
                  err_nxt = 1'b1;
                end
              end

              KEY_NEG: neg_nxt = ~neg;

              KEY_CLR: begin
                if (entry_dirty) begin
                  mag_nxt  = '0;
                  neg_nxt  = 1'b0;
                  dcnt_nxt = '0;
                end else if (state == ENTRY_B) begin
                  // Empty B entry: back out to A and discard operand A.
                  op_a_nxt      = '0;
                  entry_sel_nxt = 1'b0;
                  state_nxt     = ENTRY_A;
                end
              end

              KEY_ENTER: begin
                if ((state == ENTRY_B) && has_value) begin
                  op_b_nxt     = disp_value;
                  op_valid_nxt = 1'b1;
                  state_nxt    = HOLD;
                end else begin
                  err_nxt = 1'b1;
                end
              end

              KEY_BKSP: begin
                if (dcnt == '0) begin
                  mag_nxt = '0;
                  neg_nxt = 1'b0;
                end else begin
                  mag_nxt  = mag_div10;
                  dcnt_nxt = dcnt - DCNT_ONE;
                end
              end

              default: ;  // key F: deliberately ignored, no error
            endcase
          end
        end
      end

      default: state_nxt = ENTRY_A;
    endcase
  end

  // State, operand and status registers with asynchronous abort on reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ENTRY_A;
      mag       <= '0;
      neg       <= 1'b0;
      dcnt      <= '0;
      key_prev  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      entry_sel <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mag       <= mag_nxt;
      neg       <= neg_nxt;
      dcnt      <= dcnt_nxt;
      key_prev  <= key_pressed;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_valid  <= op_valid_nxt;
      entry_sel <= entry_sel_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl
// Directed bench for operand_entry_ctrl at WIDTH=8, MAX_DIGITS=3.
module tb_operand_entry_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       key_value;
  logic             key_pressed;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic [WIDTH-1:0] disp_value;
  logic             entry_sel;
  logic             err;

  int   tests = 0;
  int   fails = 0;
  logic last_err;

  operand_entry_ctrl #(
    .WIDTH     (WIDTH),
    .MAX_DIGITS(3),
    .DCNT_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_value  (key_value),
    .key_pressed(key_pressed),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .disp_value (disp_value),
    .entry_sel  (entry_sel),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time bound so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One press: key high for one cycle, err sampled one cycle after the
  // rising edge (when a rejection pulse would be visible), then one idle cycle.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_value   = k;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    last_err    = err;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b0;
    key_value   = 4'h0;
    key_pressed = 1'b0;
    op_ready    = 1'b0;
    last_err    = 1'b0;

    // Reset state
    #12;
    check("rst_op_a", op_a, 8'h00);
    check("rst_op_b", op_b, 8'h00);
    check("rst_op_valid", 8'(op_valid), 8'h00);
    check("rst_disp", disp_value, 8'h00);
    check("rst_entry_sel", 8'(entry_sel), 8'h00);
    check("rst_err", 8'(err), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 12 * -5 with op_ready low, then handshake
    press(4'h1);
    press(4'h2);
    check("a_entry_12", disp_value, 8'h0C);
    press(4'hA);
    check("star_op_a", op_a, 8'h0C);
    check("star_entry_sel", 8'(entry_sel), 8'h01);
    check("star_disp_clear", disp_value, 8'h00);
    press(4'hB);
    check("neg_zero_disp", disp_value, 8'h00);
    press(4'h5);
    check("b_entry_m5", disp_value, 8'hFB);
    press(4'hD);
    check("enter_op_b", op_b, 8'hFB);
    check("enter_op_valid", 8'(op_valid), 8'h01);
    repeat (10) @(negedge clk);
    check("hold_valid_10cyc", 8'(op_valid), 8'h01);
    press(4'h7);
    check("hold_key_no_err", 8'(last_err), 8'h00);
    check("hold_key_ignored", disp_value, 8'hFB);
    check("hold_op_a_stable", op_a, 8'h0C);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("hs_valid_drop", 8'(op_valid), 8'h00);
    check("hs_entry_sel", 8'(entry_sel), 8'h00);
    check("hs_disp", disp_value, 8'h00);
    check("hs_op_a_kept", op_a, 8'h0C);
    check("hs_op_b_kept", op_b, 8'hFB);

    // Range limit and digit-count limit
    press(4'h1);
    press(4'h2);
    press(4'h8);
    check("ovf_err_pulse", 8'(last_err), 8'h01);
    check("ovf_err_one_cycle", 8'(err), 8'h00);
    check("ovf_disp_kept", disp_value, 8'h0C);
    press(4'hC);
    press(4'h1);
    press(4'h2);
    press(4'h7);
    check("max_127", disp_value, 8'h7F);
    check("max_127_no_err", 8'(last_err), 8'h00);
    press(4'h4);
    check("dcnt_limit_err", 8'(last_err), 8'h01);
    check("dcnt_limit_disp", disp_value, 8'h7F);
    press(4'hC);
    check("clear_disp", disp_value, 8'h00);

    // Backspace down to empty, then sign and digit
    press(4'h4);
    press(4'h5);
    check("bk_45", disp_value, 8'h2D);
    press(4'hE);
    check("bk_4", disp_value, 8'h04);
    press(4'hE);
    check("bk_0", disp_value, 8'h00);
    press(4'hE);
    check("bk_empty_disp", disp_value, 8'h00);
    check("bk_empty_no_err", 8'(last_err), 8'h00);
    press(4'hB);
    press(4'h7);
    check("neg_7", disp_value, 8'hF9);
    press(4'hC);

    // Leading zeros do not consume digit slots; op_ready outside HOLD ignored
    op_ready = 1'b1;
    press(4'h0);
    press(4'h0);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    op_ready = 1'b0;
    check("lead_zero_123", disp_value, 8'h7B);
    check("lead_zero_no_err", 8'(last_err), 8'h00);
    check("ready_ignored_sel", 8'(entry_sel), 8'h00);
    press(4'hF);
    check("key_f_no_err", 8'(last_err), 8'h00);
    check("key_f_disp", disp_value, 8'h7B);
    press(4'hC);

    // Held key: exactly one digit
    @(negedge clk);
    key_value   = 4'h8;
    key_pressed = 1'b1;
    repeat (20) @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    check("held_key_once", disp_value, 8'h08);
    press(4'hD);
    check("enter_in_a_err", 8'(last_err), 8'h01);
    check("enter_in_a_sel", 8'(entry_sel), 8'h00);
    check("enter_in_a_disp", disp_value, 8'h08);
    press(4'hC);
    press(4'hA);
    check("star_empty_err", 8'(last_err), 8'h01);
    check("star_empty_sel", 8'(entry_sel), 8'h00);

    // Two-step clear in ENTRY_B
    press(4'h6);
    press(4'hA);
    check("b_op_a_6", op_a, 8'h06);
    press(4'hA);
    check("star_in_b_err", 8'(last_err), 8'h01);
    press(4'h3);
    check("b_entry_3", disp_value, 8'h03);
    press(4'hC);
    check("b_clear_disp", disp_value, 8'h00);
    check("b_clear_sel", 8'(entry_sel), 8'h01);
    press(4'hD);
    check("enter_empty_b_err", 8'(last_err), 8'h01);
    check("enter_empty_b_valid", 8'(op_valid), 8'h00);
    press(4'hC);
    check("b_back_sel", 8'(entry_sel), 8'h00);
    check("b_back_op_a", op_a, 8'h00);

    // Asynchronous reset during HOLD
    press(4'h2);
    press(4'hA);
    press(4'h3);
    press(4'hD);
    check("pre_rst_valid", 8'(op_valid), 8'h01);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 8'(op_valid), 8'h00);
    check("async_rst_op_a", op_a, 8'h00);
    check("async_rst_op_b", op_b, 8'h00);
    check("async_rst_disp", disp_value, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(4'h9);
    press(4'hA);
    press(4'h9);
    press(4'hD);
    check("post_rst_op_a", op_a, 8'h09);
    check("post_rst_op_b", op_b, 8'h09);
    check("post_rst_valid", 8'(op_valid), 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
